spi_shifter_gen: RTL

Parametrised SPI slave shifter, the next generation of the team's fixed 8-bit mode-0 shifter. It adds configurable word width, SPI mode (CPOL/CPHA), bit order, a TX FIFO of configurable depth, underrun fill and an in-frame word counter. All SPI pins are oversampled in the clk domain, and all user-side interfaces are synchronous to clk. The block sits between the SPI pads and a byte/word-level protocol engine (command decoder or bus bridge).

---
 rtl/spi_shifter_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spi_shifter_gen.sv
// SPI slave shifter with parametrised width, mode and bit order, oversampled in clk.
// state | meaning: IDLE = ssn high, sck ignored; ACTIVE = frame in progress.
module spi_shifter_gen #(
  parameter int                    DATA_WIDTH  = 8,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int                    TX_DEPTH    = 2,
  parameter logic [DATA_WIDTH-1:0] FILL        = '1,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_i,
  input  logic                  ssn_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [DATA_WIDTH-1:0] rx_dat_o,
  output logic                  rx_vld_o,
  input  logic [DATA_WIDTH-1:0] tx_dat_i,
  input  logic                  tx_vld_i,
  output logic                  tx_rdy_o,
  output logic                  tx_overrun_o,
  output logic                  tx_underrun_o,
  output logic                  tx_word_done_o,
  output logic                  start_o,
  output logic                  busy_o,
  output logic [15:0]           word_cnt_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sck_sync_q, ssn_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ssn_prev_q;
  logic                   sck_s, ssn_s, mosi_s;
  logic                   sck_rise, sck_fall, ssn_rise, ssn_fall;
  logic                   sample_edge, shift_edge, start_cond, stop_cond, load, pop, push, full;

  logic [0:0]            state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, rx_dat_q, rx_dat_d, tx_sr_q, tx_sr_d;
  logic                  rx_vld_q, rx_vld_d, done_q, done_d, miso_q, miso_d;
  logic                  underrun_q, underrun_d, start_q, start_d, overrun_q;
  logic [15:0]           word_cnt_q, word_cnt_d;

  logic [DATA_WIDTH-1:0] fifo_q [TX_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;

  // ssn chain resets to "selected" so a frame already running at reset release never starts
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL}};
      ssn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL;
      ssn_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q  <= sck_s;
      ssn_prev_q  <= ssn_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ssn_s    = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ssn_rise = ssn_s & ~ssn_prev_q;
  assign ssn_fall = ~ssn_s & ssn_prev_q;

  assign sample_edge = (state_q == ST_ACTIVE) && ((CPOL ^ CPHA) ? sck_fall : sck_rise);
  assign shift_edge  = (state_q == ST_ACTIVE) && ((CPOL ^ CPHA) ? sck_rise : sck_fall);
  assign start_cond  = ssn_fall && (state_q == ST_IDLE);
  assign stop_cond   = ssn_rise && (state_q == ST_ACTIVE);
  // a shift edge with bit_cnt==0 is always the first shift edge of a word in both phases
  assign load = ((CPHA == 1'b0) && start_cond) || (shift_edge && (bit_cnt_q == '0));
  assign pop  = load && (count_q != '0);
  assign full = (count_q == CW'(TX_DEPTH));
  assign push = tx_vld_i && !full;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_dat_d   = rx_dat_q;
    rx_vld_d   = 1'b0;
    done_d     = 1'b0;
    word_cnt_d = word_cnt_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    underrun_d = 1'b0;
    start_d    = 1'b0;
    if (start_cond) begin
      state_d    = ST_ACTIVE;
      start_d    = 1'b1;
      word_cnt_d = '0;
      bit_cnt_d  = '0;
    end
    if (sample_edge) begin
      rx_sr_d = MSB_FIRST ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
      if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
        rx_dat_d  = rx_sr_d;
        rx_vld_d  = 1'b1;
        done_d    = 1'b1;
        bit_cnt_d = '0;
        if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
    if (load) begin
      tx_sr_d    = pop ? fifo_q[rd_ptr_q] : FILL;
      underrun_d = !pop;
    end else if (shift_edge) begin
      tx_sr_d = MSB_FIRST ? {tx_sr_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
    end
    if (load || shift_edge) miso_d = MSB_FIRST ? tx_sr_d[DATA_WIDTH-1] : tx_sr_d[0];
    if (stop_cond) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      rx_dat_q   <= '0;
      rx_vld_q   <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
      tx_sr_q    <= '0;
      miso_q     <= 1'b0;
      underrun_q <= 1'b0;
      start_q    <= 1'b0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_dat_q   <= rx_dat_d;
      rx_vld_q   <= rx_vld_d;
      done_q     <= done_d;
      word_cnt_q <= word_cnt_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      underrun_q <= underrun_d;
      start_q    <= start_d;
      overrun_q  <= tx_vld_i && full;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= tx_dat_i;
  end

  assign miso_o         = miso_q;
  assign miso_oe_o      = (state_q == ST_ACTIVE);
  assign busy_o         = (state_q == ST_ACTIVE);
  assign rx_dat_o       = rx_dat_q;
  assign rx_vld_o       = rx_vld_q;
  assign tx_rdy_o       = !full;
  assign tx_overrun_o   = overrun_q;
  assign tx_underrun_o  = underrun_q;
  assign tx_word_done_o = done_q;
  assign start_o        = start_q;
  assign word_cnt_o     = word_cnt_q;

endmodule
